// File: rtl/sisc_fetch_unit.sv
// sisc_fetch_unit: instruction-side partner of the SISC controller.
// Holds the PC, the instruction register and the status register. Fetches
// instructions over a req/ack handshake. Resolves conditional branches
// against the mm condition mask of the instruction in the IR.
module sisc_fetch_unit #(
    parameter int PC_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_go,
    input  logic            br_go,
    input  logic            stat_en,
    input  logic [3:0]      alu_stat,
    input  logic [31:0]     im_data,
    input  logic            im_ack,
    output logic            im_req,
    output logic [PC_W-1:0] im_addr,
    output logic [31:0]     ir,
    output logic [3:0]      opcode,
    output logic [3:0]      mm,
    output logic [3:0]      stat,
    output logic            ir_valid,
    output logic            br_taken,
    output logic            halted
);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    localparam logic [3:0] OP_BRA = 4'd4;
    localparam logic [3:0] OP_BRR = 4'd5;
    localparam logic [3:0] OP_BNE = 4'd6;
    localparam logic [3:0] OP_BNR = 4'd7;
    localparam logic [3:0] OP_HLT = 4'd15;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] imm_pc;
    logic [PC_W-1:0] br_target;
    logic            cond;
    logic            br_take;

    assign imm_pc  = ir[PC_W-1:0];
    assign im_addr = pc;
    assign opcode  = ir[31:28];
    assign mm      = ir[27:24];

    // Branch decision for the instruction currently in the IR. PC_W never
    // exceeds 16, so the low PC_W bits of pc + sext(imm) are the same as
    // pc + imm[PC_W-1:0]. No explicit sign extension is needed.
    always_comb begin
        cond      = |(stat & mm);
        br_take   = 1'b0;
        br_target = pc;
        case (opcode)
            OP_BRA: begin
                br_take   = cond;
                br_target = imm_pc;
            end
            OP_BRR: begin
                br_take   = cond;
                br_target = pc + imm_pc;
            end
            OP_BNE: begin
                br_take   = !cond;
                br_target = imm_pc;
            end
            OP_BNR: begin
                br_take   = !cond;
                br_target = pc + imm_pc;
            end
            default: begin
                br_take   = 1'b0;
                br_target = pc;
            end
        endcase
    end

    // Fetch FSM, PC/IR/status registers and the registered strobe outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= '0;
            ir       <= '0;
            stat     <= '0;
            im_req   <= 1'b0;
            ir_valid <= 1'b0;
            br_taken <= 1'b0;
            halted   <= 1'b0;
        end else begin
            ir_valid <= 1'b0;
            br_taken <= 1'b0;
            if (opcode == OP_HLT) begin
                halted <= 1'b1;
            end
            if (stat_en) begin
                stat <= alu_stat;
            end
            case (state)
                IDLE: begin
                    if (br_go && br_take) begin
                        pc       <= br_target;
                        br_taken <= 1'b1;
                    end
                    if (fetch_go && !halted) begin
                        state  <= REQ;
                        im_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (im_ack) begin
                        ir       <= im_data;
                        pc       <= pc + PC_W'(1);
                        ir_valid <= 1'b1;
                        im_req   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    im_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Testbench for sisc_fetch_unit.
// A fetch scoreboard holds the expected IR and next-PC for every fetch.
// A table of branch vectors is applied after each vector's PC and IR are set up.
// Hand-written sequences cover the multi-cycle corner cases.
module tb_sisc_fetch_unit;

    localparam int PC_W = 16;

    logic            clk;
    logic            rst;
    logic            fetch_go;
    logic            br_go;
    logic            stat_en;
    logic [3:0]      alu_stat;
    logic [31:0]     im_data;
    logic            im_ack;
    logic            im_req;
    logic [PC_W-1:0] im_addr;
    logic [31:0]     ir;
    logic [3:0]      opcode;
    logic [3:0]      mm;
    logic [3:0]      stat;
    logic            ir_valid;
    logic            br_taken;
    logic            halted;

    typedef struct packed {
        logic [31:0] ir_word;
        logic [15:0] pc_after;
    } exp_t;

    typedef struct {
        logic [31:0] ir_word;
        logic [3:0]  stat_val;
        logic [15:0] pc_at_br;
        logic [15:0] exp_pc;
        logic        exp_taken;
    } br_vec_t;

    exp_t        sb[$];
    br_vec_t     vecs[12];
    logic [15:0] model_pc;
    int          compared;
    int          failed;

    sisc_fetch_unit #(.PC_W(PC_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .fetch_go (fetch_go),
        .br_go    (br_go),
        .stat_en  (stat_en),
        .alu_stat (alu_stat),
        .im_data  (im_data),
        .im_ack   (im_ack),
        .im_req   (im_req),
        .im_addr  (im_addr),
        .ir       (ir),
        .opcode   (opcode),
        .mm       (mm),
        .stat     (stat),
        .ir_valid (ir_valid),
        .br_taken (br_taken),
        .halted   (halted)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic setStat(input logic [3:0] v);
        stat_en  = 1'b1;
        alu_stat = v;
        tick();
        stat_en  = 1'b0;
        checkOutput("stat_load", 32'(stat), 32'(v));
    endtask

    // Acknowledge the pending request and score the resulting IR load
    task automatic ackFetch(input logic [31:0] data);
        exp_t e;
        sb.push_back('{ir_word: data, pc_after: model_pc + 16'd1});
        im_ack  = 1'b1;
        im_data = data;
        tick();
        im_ack  = 1'b0;
        im_data = '0;
        if (ir_valid) begin
            e = sb.pop_front();
            checkOutput("fetch_ir", ir, e.ir_word);
            checkOutput("fetch_pc", 32'(im_addr), 32'(e.pc_after));
        end else begin
            compared++;
            failed++;
            $display("[TB] FAIL ir_valid_missing: got 0 expected 1");
            void'(sb.pop_front());
        end
        checkOutput("im_req_after_ack", 32'(im_req), 32'd0);
        model_pc = model_pc + 16'd1;
        tick();
        checkOutput("ir_valid_single", 32'(ir_valid), 32'd0);
    endtask

    task automatic applyStimulus(input logic [31:0] data, input int waits);
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        checkOutput("im_req_wait", 32'(im_req), 32'd1);
        checkOutput("im_addr_wait", 32'(im_addr), 32'(model_pc));
        for (int w = 0; w < waits; w++) begin
            tick();
            checkOutput("im_req_wait", 32'(im_req), 32'd1);
            checkOutput("im_addr_wait", 32'(im_addr), 32'(model_pc));
        end
        ackFetch(data);
    endtask

    task automatic doBranch(input logic [15:0] exp_pc, input logic exp_taken);
        br_go = 1'b1;
        tick();
        br_go = 1'b0;
        checkOutput("br_pc", 32'(im_addr), 32'(exp_pc));
        checkOutput("br_taken", 32'(br_taken), 32'(exp_taken));
        tick();
        checkOutput("br_taken_pulse", 32'(br_taken), 32'd0);
        model_pc = exp_pc;
    endtask

    // Main test sequence
    initial begin
        logic [15:0] pre;
        compared = 0;
        failed   = 0;
        model_pc = '0;
        rst      = 1'b1;
        fetch_go = 1'b0;
        br_go    = 1'b0;
        stat_en  = 1'b0;
        alu_stat = '0;
        im_data  = '0;
        im_ack   = 1'b0;

        vecs[0]  = '{32'h4100_0020, 4'h1, 16'h0010, 16'h0020, 1'b1};
        vecs[1]  = '{32'h4100_0020, 4'h0, 16'h0010, 16'h0010, 1'b0};
        vecs[2]  = '{32'h5F00_FFFD, 4'h2, 16'h0001, 16'hFFFE, 1'b1};
        vecs[3]  = '{32'h5200_0010, 4'h4, 16'h0100, 16'h0100, 1'b0};
        vecs[4]  = '{32'h6400_0300, 4'h0, 16'h0005, 16'h0300, 1'b1};
        vecs[5]  = '{32'h6400_0300, 4'h4, 16'h0005, 16'h0005, 1'b0};
        vecs[6]  = '{32'h7000_0002, 4'hF, 16'hFFFF, 16'h0001, 1'b1};
        vecs[7]  = '{32'h4000_0055, 4'hF, 16'h0030, 16'h0030, 1'b0};
        vecs[8]  = '{32'h8F00_1234, 4'hF, 16'h0040, 16'h0040, 1'b0};
        vecs[9]  = '{32'h7800_FFF0, 4'h0, 16'h0008, 16'hFFF8, 1'b1};
        vecs[10] = '{32'h4800_1234, 4'h8, 16'h0000, 16'h1234, 1'b1};
        vecs[11] = '{32'h5100_0003, 4'h1, 16'h7FFE, 16'h8001, 1'b1};

        // Reset state, then a fetch with three wait cycles
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_im_req", 32'(im_req), 32'd0);
        checkOutput("rst_pc", 32'(im_addr), 32'd0);
        checkOutput("rst_ir", ir, 32'd0);
        checkOutput("rst_stat", 32'(stat), 32'd0);
        checkOutput("rst_ir_valid", 32'(ir_valid), 32'd0);
        checkOutput("rst_br_taken", 32'(br_taken), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        applyStimulus(32'h8800_0005, 3);
        checkOutput("opcode_alu", 32'(opcode), 32'd8);
        checkOutput("mm_alu", 32'(mm), 32'd8);

        // Branch vector table
        for (int i = 0; i < 12; i++) begin
            pre = vecs[i].pc_at_br - 16'd1;
            setStat(4'hF);
            applyStimulus({16'h4F00, pre}, i % 3);
            doBranch(pre, 1'b1);
            applyStimulus(vecs[i].ir_word, 0);
            setStat(vecs[i].stat_val);
            doBranch(vecs[i].exp_pc, vecs[i].exp_taken);
        end

        // Simultaneous br_go and fetch_go: request goes out at the target
        setStat(4'h0);
        applyStimulus(32'h6400_0040, 0);
        br_go    = 1'b1;
        fetch_go = 1'b1;
        tick();
        br_go    = 1'b0;
        fetch_go = 1'b0;
        checkOutput("simul_br_taken", 32'(br_taken), 32'd1);
        checkOutput("simul_im_req", 32'(im_req), 32'd1);
        checkOutput("simul_im_addr", 32'(im_addr), 32'h0040);
        model_pc = 16'h0040;
        ackFetch(32'h0000_0000);

        // Simultaneous stat_en and br_go: branch sees the old status
        setStat(4'h0);
        applyStimulus(32'h4200_0077, 1);
        stat_en  = 1'b1;
        alu_stat = 4'h2;
        br_go    = 1'b1;
        tick();
        stat_en  = 1'b0;
        br_go    = 1'b0;
        checkOutput("old_stat_br_taken", 32'(br_taken), 32'd0);
        checkOutput("old_stat_pc", 32'(im_addr), 32'(model_pc));
        checkOutput("old_stat_new_stat", 32'(stat), 32'h2);
        tick();
        doBranch(16'h0077, 1'b1);

        // im_ack outside REQ is ignored
        im_ack  = 1'b1;
        im_data = 32'hFFFF_FFFF;
        tick();
        im_ack  = 1'b0;
        im_data = '0;
        checkOutput("stray_ack_ir", ir, 32'h4200_0077);
        checkOutput("stray_ack_valid", 32'(ir_valid), 32'd0);
        checkOutput("stray_ack_pc", 32'(im_addr), 32'h0077);

        // br_go during REQ is ignored even when the branch would be taken
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        br_go    = 1'b1;
        tick();
        br_go    = 1'b0;
        checkOutput("req_br_taken", 32'(br_taken), 32'd0);
        checkOutput("req_br_pc", 32'(im_addr), 32'(model_pc));
        checkOutput("req_br_im_req", 32'(im_req), 32'd1);
        ackFetch(32'h0000_0000);

        // Reset in the middle of a fetch, then a late ack
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        im_ack  = 1'b1;
        im_data = 32'h1234_5678;
        tick();
        im_ack  = 1'b0;
        im_data = '0;
        checkOutput("midrst_im_req", 32'(im_req), 32'd0);
        checkOutput("midrst_ir", ir, 32'd0);
        checkOutput("midrst_pc", 32'(im_addr), 32'd0);
        checkOutput("midrst_ir_valid", 32'(ir_valid), 32'd0);
        model_pc = 16'h0000;

        // HLT sets halted and blocks later fetches
        applyStimulus(32'hF000_0000, 0);
        checkOutput("halted_set", 32'(halted), 32'd1);
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        checkOutput("halted_no_req", 32'(im_req), 32'd0);
        tick();
        checkOutput("halted_no_req_later", 32'(im_req), 32'd0);
        checkOutput("halted_sticky", 32'(halted), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("halted_cleared", 32'(halted), 32'd0);

        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
